dcache_ld_issue: RTL

Load-issue sequencer that sits directly upstream of one `std_nbdcache` request port (the load-unit port). It accepts whole-address load requests from the core over a valid/ready handshake and converts them into the cache's two-phase protocol: index phase with `data_req`/`data_gnt`, then tag phase with `tag_valid` one cycle after grant. An in-order ID FIFO tracks outstanding loads so responses return tagged, and a flush drops in-flight loads cleanly.

---
 rtl/std_cache_pkg.sv | 62 ++++++
 rtl/dcache_ld_issue_if.sv | 27 ++
 rtl/ld_id_fifo.sv | 61 ++++++
 rtl/dcache_ld_issue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/std_cache_pkg.sv
// Cache port types, address split and load-issue types.
// Shared by the load-issue sequencer and its ID FIFO.
package std_cache_pkg;

  localparam int unsigned PLEN = 56;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH = 44;
  localparam int unsigned LD_ID_MAX_W = 16;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    TAG
  } ld_issue_state_e;

  typedef struct packed {
    logic [LD_ID_MAX_W-1:0] id;
    logic                   killed;
  } ld_fifo_entry_t;

  function automatic logic [7:0] be_gen(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic [7:0] m;
    unique case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic [2:0] m;
    m = ~(3'b111 << size);
    return |(off & m);
  endfunction

endpackage

// File: rtl/dcache_ld_issue_if.sv
// Core-side load request / response bundle of the load-issue sequencer.
// master = core side, slave = sequencer side.
interface dcache_ld_issue_if #(
  parameter int unsigned IdWidth = 4
);
  logic                           ld_valid;
  logic                           ld_ready;
  logic [std_cache_pkg::PLEN-1:0] ld_paddr;
  logic [1:0]                     ld_size;
  logic [IdWidth-1:0]             ld_id;
  logic                           rsp_valid;
  logic [63:0]                    rsp_data;
  logic [IdWidth-1:0]             rsp_id;
  logic                           rsp_misaligned;

  modport master (
    output ld_valid, ld_paddr, ld_size, ld_id,
    input  ld_ready, rsp_valid, rsp_data,
    input  rsp_id, rsp_misaligned
  );

  modport slave (
    input  ld_valid, ld_paddr, ld_size, ld_id,
    output ld_ready, rsp_valid, rsp_data,
    output rsp_id, rsp_misaligned
  );
endinterface

// File: rtl/ld_id_fifo.sv
// In-order ID FIFO for outstanding loads.
// flush_i marks every stored entry killed; push writes a live entry.
module ld_id_fifo
  import std_cache_pkg::*;
#(
  parameter int unsigned NrOutstanding = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               push_i,
  input  ld_fifo_entry_t                     data_i,
  input  logic                               pop_i,
  output ld_fifo_entry_t                     head_o,
  output logic [$clog2(NrOutstanding):0]     count_o
);
  localparam int unsigned PtrW = $clog2(NrOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  ld_fifo_entry_t [NrOutstanding-1:0] mem_q, mem_d;
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush_i) begin
      for (int i = 0; i < NrOutstanding; i++) begin
        mem_d[i].killed = 1'b1;
      end
    end
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d = wr_q + 1'b1;
    end
    if (pop_i) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/dcache_ld_issue.sv
// Load-issue sequencer: valid/ready loads -> cache index/tag phases.
// Optional misalignment check: DCACHE_LD_ISSUE_MISALIGN_CHK_EN.
module dcache_ld_issue
  import std_cache_pkg::*;
#(
  parameter int unsigned NrOutstanding = 2,
  parameter int unsigned IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               ld_valid_i,
  output logic               ld_ready_o,
  input  logic [PLEN-1:0]    ld_paddr_i,
  input  logic [1:0]         ld_size_i,
  input  logic [IdWidth-1:0] ld_id_i,
  output logic               rsp_valid_o,
  output logic [63:0]        rsp_data_o,
  output logic [IdWidth-1:0] rsp_id_o,
  output logic               rsp_misaligned_o,
  output dcache_req_i_t      req_port_o,
  input  dcache_req_o_t      req_port_i
);
  localparam int unsigned CntW = $clog2(NrOutstanding) + 1;
  localparam int unsigned OccW = CntW + 1;

  ld_issue_state_e state_q, state_d;
  logic [PLEN-1:0]    paddr_q, paddr_d;
  logic [1:0]         size_q, size_d;
  logic [IdWidth-1:0] id_q, id_d;

  ld_fifo_entry_t  head, push_ent;
  logic [CntW-1:0] count, count_eff;
  logic [OccW-1:0] occ;
  logic accept, issue, push, pop, cache_rsp;
  logic mis, mis_block;
  logic unused_id_hi;

  // A same-cycle pop frees a slot for the handshake.
  assign pop       = req_port_i.data_rvalid & (count != '0);
  assign count_eff = count - CntW'(pop);
  assign occ       = OccW'(count_eff) + OccW'(state_q == TAG);

  assign ld_ready_o = (state_q != WAIT_GNT)
                    & (occ < OccW'(NrOutstanding))
                    & ~flush_i & ~mis_block;

  assign accept = ld_valid_i & ld_ready_o;
  assign issue  = accept & ~mis;

  assign paddr_d = issue ? ld_paddr_i : paddr_q;
  assign size_d  = issue ? ld_size_i  : size_q;
  assign id_d    = issue ? ld_id_i    : id_q;

  assign push_ent     = '{id: LD_ID_MAX_W'(id_q), killed: 1'b0};
  assign unused_id_hi = ^head.id;

  always_comb begin
    state_d    = state_q;
    req_port_o = '0;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          req_port_o.data_req      = 1'b1;
          req_port_o.address_index =
            paddr_q[DCACHE_INDEX_WIDTH-1:0];
          req_port_o.data_size     = size_q;
          req_port_o.data_be       =
            be_gen(size_q, paddr_q[2:0]);
          if (req_port_i.data_gnt) begin
            push    = 1'b1;
            state_d = TAG;
          end
        end
      end
      TAG: begin
        if (flush_i) begin
          req_port_o.kill_req = 1'b1;
        end else begin
          req_port_o.tag_valid   = 1'b1;
          req_port_o.address_tag = paddr_q[
            DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:
            DCACHE_INDEX_WIDTH];
        end
        state_d = issue ? WAIT_GNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      paddr_q <= '0;
      size_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      size_q  <= size_d;
      id_q    <= id_d;
    end
  end

  ld_id_fifo #(
    .NrOutstanding(NrOutstanding)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .push_i (push),
    .data_i (push_ent),
    .pop_i  (pop),
    .head_o (head),
    .count_o(count)
  );

  // Killed heads are popped silently; flush hides the popping head too.
  assign cache_rsp = pop & ~head.killed & ~flush_i;

`ifdef DCACHE_LD_ISSUE_MISALIGN_CHK_EN
  logic               mis_pend_q, mis_pend_d;
  logic [IdWidth-1:0] mis_id_q, mis_id_d;

  assign mis       = is_misaligned(ld_size_i, ld_paddr_i[2:0]);
  assign mis_block = mis_pend_q;
  // Pending misaligned response yields to a colliding cache response.
  assign mis_pend_d = ~flush_i & ((accept & mis)
                    | (mis_pend_q & cache_rsp));
  assign mis_id_d   = (accept & mis) ? ld_id_i : mis_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mis_pend_q <= 1'b0;
      mis_id_q   <= '0;
    end else begin
      mis_pend_q <= mis_pend_d;
      mis_id_q   <= mis_id_d;
    end
  end
`else
  assign mis       = 1'b0;
  assign mis_block = 1'b0;
`endif

  always_comb begin
    rsp_valid_o      = cache_rsp;
    rsp_misaligned_o = 1'b0;
    rsp_data_o       = cache_rsp ? req_port_i.data_rdata : '0;
    rsp_id_o         = cache_rsp ? head.id[IdWidth-1:0] : '0;
`ifdef DCACHE_LD_ISSUE_MISALIGN_CHK_EN
    if (!cache_rsp && mis_pend_q && !flush_i) begin
      rsp_valid_o      = 1'b1;
      rsp_misaligned_o = 1'b1;
      rsp_id_o         = mis_id_q;
    end
`endif
  end

endmodule
